// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared definitions for the snooping-bus arbiter: default sizes, FSM states
// and coherence message field positions.
package snoop_bus_arbiter_pkg;

  localparam int N_CPU_DEF      = 3;
  localparam int MSG_W_DEF      = 10;
  localparam int ID_W_DEF       = 2;
  localparam int SNOOP_WAIT_DEF = 2;

  // Coherence message layout carried on the broadcast bus.
  localparam int MSG_OPCODE_MSB = 9;
  localparam int MSG_OPCODE_LSB = 6;
  localparam int MSG_TAG_MSB    = 5;
  localparam int MSG_TAG_LSB    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BROADCAST = 2'd1,
    SNOOP     = 2'd2,
    RESPOND   = 2'd3
  } state_e;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// CPU-side request/snoop signals and arbiter-side broadcast results.
// The CPUs use the master modport; the arbiter uses the slave modport.
interface snoop_bus_arbiter_if #(
  parameter int N_CPU = 3,
  parameter int MSG_W = 10,
  parameter int ID_W  = 2
);
  logic [N_CPU-1:0]       req;
  logic [N_CPU*MSG_W-1:0] msg_in;
  logic [N_CPU-1:0]       snoop_hit;

  logic [N_CPU-1:0]       gnt;
  logic [MSG_W-1:0]       bus;
  logic                   bus_valid;
  logic [ID_W-1:0]        bus_owner;
  logic                   shared;
  logic [N_CPU-1:0]       done;
  logic                   busy;

  modport master (
    output req, msg_in, snoop_hit,
    input  gnt, bus, bus_valid, bus_owner, shared, done, busy
  );

  modport slave (
    input  req, msg_in, snoop_hit,
    output gnt, bus, bus_valid, bus_owner, shared, done, busy
  );
endinterface

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_i, wrapping
// modulo N_CPU, returned both one-hot and as an index.
module snoop_bus_arbiter_rr_picker #(
  parameter int N_CPU = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_CPU-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_CPU-1:0] pick_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  logic found;

  // NOTE: every output gets a default before the search so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    for (int off = 1; off <= N_CPU; off++) begin
      for (int i = 0; i < N_CPU; i++) begin
        if (!found && req_i[i] && (i == (int'(last_i) + off) % N_CPU)) begin
          pick_o[i] = 1'b1;
          idx_o     = ID_W'(i);
          valid_o   = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter: grants one CPU round-robin, broadcasts its message,
// collects other CPUs' snoop hits into 'shared', then pulses done to the owner.
module snoop_bus_arbiter
  import snoop_bus_arbiter_pkg::*;
#(
  parameter int N_CPU      = N_CPU_DEF,
  parameter int MSG_W      = MSG_W_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int SNOOP_WAIT = SNOOP_WAIT_DEF
) (
  input logic                clock,
  input logic                clear,
  snoop_bus_arbiter_if.slave bus_if
);

  localparam int                CNT_W    = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SNOOP_WAIT - 1);
  localparam logic [ID_W-1:0]   LAST_RST = ID_W'(N_CPU - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [N_CPU-1:0]   gnt_q, gnt_d;
  logic [MSG_W-1:0]   bus_q, bus_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic               shared_q, shared_d;
  logic [N_CPU-1:0]   done_q, done_d;
  logic               busy_q, busy_d;

  logic [N_CPU-1:0]   pick;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  logic [MSG_W-1:0]   pick_msg;

  snoop_bus_arbiter_rr_picker #(
    .N_CPU (N_CPU),
    .ID_W  (ID_W)
  ) u_picker (
    .req_i   (bus_if.req),
    .last_i  (last_q),
    .pick_o  (pick),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_msg = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (pick[i]) pick_msg = bus_if.msg_in[i*MSG_W +: MSG_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    bus_d    = bus_q;
    owner_d  = owner_q;
    shared_d = shared_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    done_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick;
          owner_d  = pick_idx;
          bus_d    = pick_msg;
          valid_d  = 1'b1;
          shared_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = BROADCAST;
        end
      end
      BROADCAST: begin
        cnt_d   = CNT_LOAD;
        state_d = SNOOP;
      end
      SNOOP: begin
        // The owner answers its own broadcast too; only other caches count.
        shared_d = shared_q | (|(bus_if.snoop_hit & ~gnt_q));
        if (cnt_q == '0) begin
          done_d  = gnt_q;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        last_d  = owner_q;
        gnt_d   = '0;
        bus_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= LAST_RST;
      gnt_q    <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      owner_q  <= '0;
      shared_q <= 1'b0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      shared_q <= shared_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus_if.gnt       = gnt_q;
  assign bus_if.bus       = bus_q;
  assign bus_if.bus_valid = valid_q;
  assign bus_if.bus_owner = owner_q;
  assign bus_if.shared    = shared_q;
  assign bus_if.done      = done_q;
  assign bus_if.busy      = busy_q;

endmodule
